// File: rtl/pc_sequencer_pkg.sv
// Shared next-PC select codes, sequencer state encoding and fetch-path constants.
// Build option: PC_MISALIGN_TRAP_EN (trap on misaligned redirect targets).
package pc_sequencer_pkg;

    localparam int unsigned PC_SEL_W = 2;
    localparam int unsigned CNT_W    = 32;

    // Next-PC decision codes from branch control
    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JUMP = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JALR = 2'b10;
    localparam logic [PC_SEL_W-1:0] PC_SEL_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    // True for the selections that redirect fetch to a computed target
    function automatic logic is_redirect(input logic [PC_SEL_W-1:0] sel);
        return (sel == PC_SEL_JUMP) || (sel == PC_SEL_JALR);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC target selection, JALR bit-0 clear and misalignment detect.
// Build option: PC_MISALIGN_TRAP_EN (report misaligned targets instead of forcing alignment).
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [PC_SEL_W-1:0] pc_sel,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     pc_plus4,
    input  logic [XLEN-1:0]     imm_target,
    input  logic [XLEN-1:0]     alu_target,
    output logic [XLEN-1:0]     target_c,
    output logic                redirect_c,
    output logic                misalign_c
);

    logic [XLEN-1:0] raw_c;

    // Raw candidate; JALR always drops bit 0 before any alignment check
    always_comb begin
        raw_c = pc;
        unique case (pc_sel)
            PC_SEL_SEQ:  raw_c = pc_plus4;
            PC_SEL_JUMP: raw_c = imm_target;
            PC_SEL_JALR: raw_c = alu_target & ~XLEN'(1);
            PC_SEL_HALT: raw_c = pc;
            default:     raw_c = pc;
        endcase
    end

    assign redirect_c = is_redirect(pc_sel);

`ifdef PC_MISALIGN_TRAP_EN
    assign target_c   = raw_c;
    assign misalign_c = redirect_c && (raw_c[1:0] != 2'b00);
`else
    // Without the trap, low bits are simply discarded
    assign target_c   = raw_c & ~XLEN'(3);
    assign misalign_c = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: next-PC select, wrong-path squash, halt and redirect count.
// Build option: PC_MISALIGN_TRAP_EN (misaligned redirects halt and set the sticky misaligned flag).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_SEL_W-1:0] PC_Sel,
    input  logic                stall,
    input  logic [XLEN-1:0]     imm_target,
    input  logic [XLEN-1:0]     alu_target,
    input  logic                resume,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                flush,
    output logic                halted,
    output logic                misaligned,
    output logic [CNT_W-1:0]    redirect_cnt
);

    pc_state_e          state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q, halted_q;
    logic               mis_q, mis_d;

    logic [XLEN-1:0]    target_c;
    logic               redirect_c;
    logic               misalign_c;

    assign pc_plus4 = pc_q + XLEN'(4);

    pc_next_mux #(
        .XLEN (XLEN)
    ) u_next_mux (
        .pc_sel     (PC_Sel),
        .pc         (pc_q),
        .pc_plus4   (pc_plus4),
        .imm_target (imm_target),
        .alu_target (alu_target),
        .target_c   (target_c),
        .redirect_c (redirect_c),
        .misalign_c (misalign_c)
    );

    // State, PC, counter and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            flush_q  <= (state_d == ST_FLUSH);
            halted_q <= (state_d == ST_HALT);
            mis_q    <= mis_d;
        end
    end

    // Next-state, next-PC and counter update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;

        unique case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (PC_Sel == PC_SEL_HALT) begin
                        state_d = ST_HALT;
                    end else if (redirect_c && misalign_c) begin
                        state_d = ST_HALT;
                        mis_d   = 1'b1;
                    end else if (redirect_c) begin
                        pc_d    = target_c;
                        state_d = ST_FLUSH;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        pc_d    = pc_plus4;
                    end
                end
            end
            // Executing instruction is wrong-path: its PC_Sel is discarded
            ST_FLUSH: begin
                state_d = ST_RUN;
                if (!stall) begin
                    pc_d = pc_plus4;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    pc_d    = pc_plus4;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc_out       = pc_q;
    assign flush        = flush_q;
    assign halted       = halted_q;
    assign redirect_cnt = cnt_q;

`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan steps then random traffic vs a reference model.
module tb_pc_sequencer;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      PC_Sel;
    logic            stall;
    logic [31:0]     imm_target;
    logic [31:0]     alu_target;
    logic            resume;
    logic [31:0]     pc_out;
    logic [31:0]     pc_plus4;
    logic            flush;
    logic            halted;
    logic            misaligned;
    logic [31:0]     redirect_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: plain architectural view of the sequencer
    logic [31:0] m_pc   = RST_PC;
    logic [31:0] m_cnt  = '0;
    bit          m_wrong_path = 1'b0;
    bit          m_halt = 1'b0;
    bit          m_mis  = 1'b0;

    pc_sequencer #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_Sel       (PC_Sel),
        .stall        (stall),
        .imm_target   (imm_target),
        .alu_target   (alu_target),
        .resume       (resume),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .flush        (flush),
        .halted       (halted),
        .misaligned   (misaligned),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the architectural rules to one sampled set of inputs
    task automatic model_edge();
        logic [31:0] t;
        if (rst) begin
            m_pc = RST_PC; m_cnt = '0; m_wrong_path = 0; m_halt = 0; m_mis = 0;
        end else if (m_wrong_path) begin
            m_wrong_path = 0;
            if (!stall) m_pc = m_pc + 32'd4;
        end else if (m_halt) begin
            if (resume) begin
                m_halt = 0;
                m_pc = m_pc + 32'd4;
            end
        end else if (!stall) begin
            if (PC_Sel == 2'd0) begin
                m_pc = m_pc + 32'd4;
            end else if (PC_Sel == 2'd3) begin
                m_halt = 1;
            end else begin
                t = (PC_Sel == 2'd1) ? imm_target : (alu_target & ~32'd1);
`ifdef PC_MISALIGN_TRAP_EN
                if (t % 4 != 0) begin
                    m_halt = 1;
                    m_mis  = 1;
                end else begin
                    m_pc = t;
                    m_wrong_path = 1;
                    m_cnt = m_cnt + 32'd1;
                end
`else
                m_pc = t - (t % 4);
                m_wrong_path = 1;
                m_cnt = m_cnt + 32'd1;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_out,       m_pc);
        chk({tag, ".pc4"},   pc_plus4,     m_pc + 32'd4);
        chk({tag, ".flush"}, 32'(flush),   32'(m_wrong_path));
        chk({tag, ".halt"},  32'(halted),  32'(m_halt));
        chk({tag, ".mis"},   32'(misaligned), 32'(m_mis));
        chk({tag, ".cnt"},   redirect_cnt, m_cnt);
    endtask

    // Drive on the falling edge, update model at the rising edge, check at the next falling edge
    task automatic step(input string tag, input logic r, input logic [1:0] sel, input logic st,
                        input logic [31:0] imm, input logic [31:0] alu, input logic res);
        rst = r; PC_Sel = sel; stall = st; imm_target = imm; alu_target = alu; resume = res;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; PC_Sel = 2'd0; stall = 1'b0; imm_target = '0; alu_target = '0; resume = 1'b0;
        @(negedge clk);

        step("reset", 1, 2'd0, 0, 0, 0, 0);
        chk("reset.pc_const", pc_out, RST_PC);

        // Sequential fetch
        step("seq1", 0, 2'd0, 0, 0, 0, 0);
        step("seq2", 0, 2'd0, 0, 0, 0, 0);
        chk("seq.pc8", pc_out, 32'h8);

        // JAL to 0x40, a JALR issued during FLUSH must be discarded
        step("jal", 0, 2'd1, 0, 32'h40, 32'h0, 0);
        chk("jal.pc40", pc_out, 32'h40);
        chk("jal.flush", 32'(flush), 32'd1);
        step("flush_ign", 0, 2'd2, 0, 32'h0, 32'h500, 0);
        chk("flush.pc44", pc_out, 32'h44);
        chk("flush.cnt1", redirect_cnt, 32'd1);

        // JALR with odd target
        step("jalr101", 0, 2'd2, 0, 0, 32'h101, 0);
        step("jalr_fl", 0, 2'd0, 0, 0, 0, 0);
        // JALR target with bit 1 set: misalign trap or forced alignment
        step("jalr102", 0, 2'd2, 0, 0, 32'h102, 0);
        step("after102", 0, 2'd0, 0, 0, 0, 1);

        // Halt at PC 0x20 and hold
        step("to1c", 0, 2'd1, 0, 32'h1C, 0, 0);
        step("fl1c", 0, 2'd0, 0, 0, 0, 0);
        chk("at20", pc_out, 32'h20);
        step("halt", 0, 2'd3, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("hold", 0, 2'(i), 0, 32'h80, 32'h80, 0);
        chk("hold.pc20", pc_out, 32'h20);
        step("resume", 0, 2'd0, 0, 0, 0, 1);
        chk("resume.pc24", pc_out, 32'h24);
        chk("resume.halted", 32'(halted), 32'd0);

        // Stall masks redirects and halt
        step("stall_j", 0, 2'd1, 1, 32'h200, 0, 0);
        step("stall_h", 0, 2'd3, 1, 0, 0, 0);
        chk("stall.pc24", pc_out, 32'h24);

        // Stall during FLUSH holds PC
        step("jmp300", 0, 2'd1, 0, 32'h300, 0, 0);
        step("fl_stall", 0, 2'd1, 1, 32'h400, 0, 0);
        step("post_fl", 0, 2'd0, 0, 0, 0, 0);

        // PC wrap through FLUSH
        step("to_top", 0, 2'd1, 0, 32'hFFFF_FFF8, 0, 0);
        step("top_fl", 0, 2'd0, 0, 0, 0, 0);
        step("wrap", 0, 2'd0, 0, 0, 0, 0);
        chk("wrap.pc0", pc_out, 32'h0);

        // Reset during FLUSH and during HALT
        step("pre_rst", 0, 2'd1, 0, 32'h600, 0, 0);
        step("rst_fl", 1, 2'd1, 0, 32'h700, 0, 1);
        chk("rst_fl.flush", 32'(flush), 32'd0);
        step("pre_h", 0, 2'd3, 0, 0, 0, 0);
        step("rst_h", 1, 2'd0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(63) == 0), 2'($urandom_range(3)),
                 ($urandom_range(3) == 0), $urandom, $urandom,
                 ($urandom_range(5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
